// File: rtl/dp_arbiter_if.sv
// Request, response and shared-datapath signal bundle for dp_arbiter.
// slave: arbiter side. master: requester/datapath side.
interface dp_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic [7:0]        dp_data_in;
    logic              dp_start;
    logic [7:0]        dp_data_out;
    logic              dp_valid;
    logic              busy;

    modport slave (
        input  req_valid, req_data, dp_data_out, dp_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err, dp_data_in, dp_start, busy
    );

    modport master (
        output req_valid, req_data, dp_data_out, dp_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err, dp_data_in, dp_start, busy
    );
endinterface

// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one 8-bit datapath among NREQ requesters.
// Optional WAIT timeout/abort is enabled by defining DP_ARBITER_TIMEOUT_EN.
module dp_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    dp_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("dp_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
    end

    logic [1:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_grant;
    logic [7:0]    r_operand;
    logic [7:0]    r_result;
`ifdef DP_ARBITER_TIMEOUT_EN
    logic          r_err;
    logic [7:0]    r_cnt;
`endif

    logic          w_any;
    logic [IW-1:0] w_winner;
    logic [IW-1:0] w_cand;
    logic [7:0]    w_ops [NREQ];

    // First pending requester at or after r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_ops[k] = bus.req_data[8*k +: 8];
            w_cand   = IW'((32'(r_ptr) + k) % NREQ);
            if (!w_any && bus.req_valid[w_cand]) begin
                w_any    = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_operand <= '0;
            r_result  <= '0;
`ifdef DP_ARBITER_TIMEOUT_EN
            r_err     <= 1'b0;
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_winner;
                        r_operand <= w_ops[w_winner];
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef DP_ARBITER_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the final counted cycle beats the abort.
                    if (bus.dp_valid) begin
                        r_result <= bus.dp_data_out;
`ifdef DP_ARBITER_TIMEOUT_EN
                        r_err    <= 1'b0;
`endif
                        r_state  <= S_RESP;
                    end
`ifdef DP_ARBITER_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'(TIMEOUT - 1)) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end
`endif
                end
                S_RESP: begin
                    r_ptr   <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while rst is high, even before the first edge.
    assign bus.req_ready  = (!rst && r_state == S_IDLE && w_any) ? (NREQ'(1) << w_winner) : '0;
    assign bus.rsp_valid  = (!rst && r_state == S_RESP) ? (NREQ'(1) << r_grant) : '0;
    assign bus.rsp_data   = rst ? '0 : r_result;
    assign bus.dp_data_in = rst ? '0 : r_operand;
    assign bus.dp_start   = !rst && (r_state == S_ISSUE);
    assign bus.busy       = !rst && (r_state != S_IDLE);
`ifdef DP_ARBITER_TIMEOUT_EN
    assign bus.rsp_err    = !rst && r_err;
`else
    assign bus.rsp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter (NREQ=4, TIMEOUT=16); timeout cases run when
// DP_ARBITER_TIMEOUT_EN is defined, an unbounded-wait case otherwise.
module tb_dp_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    dp_arbiter_if #(.NREQ(NREQ)) bus ();

    dp_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One transaction: accept cycle, ISSUE cycle, then up to 100 WAIT/RESP cycles.
    // dp_valid is raised in WAIT cycle index lat (0 = first WAIT cycle).
    task automatic run_txn(input logic [3:0] rv, input logic [31:0] rd, input logic hold,
                           input logic [7:0] res, input int lat,
                           output logic [3:0] o_ready, output logic [7:0] o_dpin,
                           output logic o_start, output logic [3:0] o_rvalid,
                           output logic [7:0] o_rdata, output logic o_rerr, output int o_lat);
        @(negedge clk);
        bus.req_valid = rv;
        bus.req_data  = rd;
        #1 o_ready = bus.req_ready;
        @(negedge clk);
        if (!hold) bus.req_valid = '0;
        bus.req_data = ~rd;
        #1 o_start = bus.dp_start;
        o_dpin   = bus.dp_data_in;
        o_rvalid = '0;
        o_rdata  = '0;
        o_rerr   = 1'b0;
        o_lat    = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.dp_valid    = (i == lat);
            bus.dp_data_out = (i == lat) ? res : 8'hEE;
            #1;
            if (bus.rsp_valid !== '0) begin
                o_rvalid = bus.rsp_valid;
                o_rdata  = bus.rsp_data;
                o_rerr   = bus.rsp_err;
                o_lat    = i + 2;
                break;
            end
        end
        bus.dp_valid = 1'b0;
        bus.req_data = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_data = 32'h44332211;
        bus.dp_valid = 1'b1;
        bus.dp_data_out = 8'hFF;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0000", bus.rsp_valid); end
        n_tests++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=00", bus.rsp_data); end
        n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got=%b exp=0", bus.rsp_err); end
        n_tests++; if (bus.dp_data_in !== 8'h00) begin n_fail++; $display("FAIL rst_dp_data_in got=%h exp=00", bus.dp_data_in); end
        n_tests++; if (bus.dp_start !== 1'b0) begin n_fail++; $display("FAIL rst_dp_start got=%b exp=0", bus.dp_start); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        bus.req_valid = '0;
        bus.dp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.rsp_data !== 8'h00 || bus.dp_data_in !== 8'h00) begin
            n_fail++; $display("FAIL post_rst busy=%b rsp_data=%h dp_data_in=%h exp 0/00/00", bus.busy, bus.rsp_data, bus.dp_data_in);
        end
    endtask

    task automatic test_single();
        logic [3:0] g, rvo; logic [7:0] dpin, rdo; logic st, reo; int lt;
        run_txn(4'b0001, 32'h00000010, 1'b0, 8'h20, 0, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (g !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", g); end
        n_tests++; if (st !== 1'b1 || dpin !== 8'h10) begin n_fail++; $display("FAIL single_issue start=%b dp_in=%h exp 1/10", st, dpin); end
        n_tests++; if (rvo !== 4'b0001 || rdo !== 8'h20 || reo !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp valid=%b data=%h err=%b exp 0001/20/0", rvo, rdo, reo);
        end
        n_tests++; if (lt !== 3) begin n_fail++; $display("FAIL single_latency got=%0d exp=3", lt); end
        @(negedge clk);
        #1;
        n_tests++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 8'h20 || bus.dp_data_in !== 8'h10 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL single_hold rsp_valid=%b rsp_data=%h dp_in=%h busy=%b ready=%b exp 0000/20/10/0/0000",
                               bus.rsp_valid, bus.rsp_data, bus.dp_data_in, bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g, rvo, eg; logic [7:0] dpin, rdo; logic st, reo; int lt;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            run_txn(4'b1111, 32'h04030201, 1'b1, 8'h50 + 8'(k), 0, g, dpin, st, rvo, rdo, reo, lt);
            n_tests++; if (g !== eg || rvo !== eg) begin n_fail++; $display("FAIL rr_grant%0d ready=%b rsp_valid=%b exp=%b", k, g, rvo, eg); end
            n_tests++; if (dpin !== 8'(k % 4 + 1) || rdo !== 8'h50 + 8'(k)) begin
                n_fail++; $display("FAIL rr_data%0d dp_in=%h rsp_data=%h exp %h/%h", k, dpin, rdo, 8'(k % 4 + 1), 8'h50 + 8'(k));
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_wrap();
        logic [3:0] g, rvo; logic [7:0] dpin, rdo; logic st, reo; int lt;
        run_txn(4'b0100, 32'h00300000, 1'b0, 8'h31, 0, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (g !== 4'b0100 || dpin !== 8'h30) begin n_fail++; $display("FAIL wrap_setup ready=%b dp_in=%h exp 0100/30", g, dpin); end
        run_txn(4'b0011, 32'h00002A1B, 1'b0, 8'h41, 0, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (g !== 4'b0001 || rvo !== 4'b0001 || dpin !== 8'h1B) begin
            n_fail++; $display("FAIL wrap_first ready=%b rsp_valid=%b dp_in=%h exp 0001/0001/1b", g, rvo, dpin);
        end
        run_txn(4'b0011, 32'h00002A1B, 1'b0, 8'h42, 0, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (g !== 4'b0010 || rvo !== 4'b0010 || dpin !== 8'h2A || rdo !== 8'h42) begin
            n_fail++; $display("FAIL wrap_second ready=%b rsp_valid=%b dp_in=%h rsp_data=%h exp 0010/0010/2a/42", g, rvo, dpin, rdo);
        end
    endtask

`ifdef DP_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] g, rvo; logic [7:0] dpin, rdo; logic st, reo; int lt;
        run_txn(4'b0010, 32'h00005500, 1'b0, 8'h99, 1000, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (rvo !== 4'b0010 || rdo !== 8'h00 || reo !== 1'b1 || lt !== 18) begin
            n_fail++; $display("FAIL timeout_abort valid=%b data=%h err=%b lat=%0d exp 0010/00/1/18", rvo, rdo, reo, lt);
        end
        run_txn(4'b0010, 32'h00005600, 1'b0, 8'h77, TIMEOUT - 1, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (rvo !== 4'b0010 || rdo !== 8'h77 || reo !== 1'b0 || lt !== 18) begin
            n_fail++; $display("FAIL timeout_race valid=%b data=%h err=%b lat=%0d exp 0010/77/0/18", rvo, rdo, reo, lt);
        end
        run_txn(4'b0010, 32'h00005700, 1'b0, 8'h78, 0, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (rvo !== 4'b0010 || rdo !== 8'h78 || reo !== 1'b0 || lt !== 3) begin
            n_fail++; $display("FAIL timeout_next valid=%b data=%h err=%b lat=%0d exp 0010/78/0/3", rvo, rdo, reo, lt);
        end
    endtask
`else
    task automatic test_long_wait();
        logic [3:0] g, rvo; logic [7:0] dpin, rdo; logic st, reo; int lt;
        run_txn(4'b0010, 32'h00005500, 1'b0, 8'h99, 40, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (rvo !== 4'b0010 || rdo !== 8'h99 || reo !== 1'b0 || lt !== 43) begin
            n_fail++; $display("FAIL long_wait valid=%b data=%h err=%b lat=%0d exp 0010/99/0/43", rvo, rdo, reo, lt);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        logic [3:0] g, rvo; logic [7:0] dpin, rdo; logic st, reo; int lt;
        logic [3:0] seen;
        @(negedge clk); bus.req_valid = 4'b0100; bus.req_data = 32'h00990000;
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midwait_busy got=%b exp=1", bus.busy); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.dp_data_in !== 8'h00 || bus.rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL midwait_after_rst busy=%b dp_in=%h rsp_valid=%b exp 0/00/0000", bus.busy, bus.dp_data_in, bus.rsp_valid);
        end
        seen = '0;
        bus.dp_valid = 1'b1; bus.dp_data_out = 8'hAB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 seen = seen | bus.rsp_valid;
        end
        bus.dp_valid = 1'b0;
        n_tests++; if (seen !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midwait_dropped rsp_valid_seen=%b busy=%b exp 0000/0", seen, bus.busy); end
        run_txn(4'b1111, 32'h5A5A5A5A, 1'b0, 8'h5A, 0, g, dpin, st, rvo, rdo, reo, lt);
        n_tests++; if (g !== 4'b0001 || rvo !== 4'b0001) begin n_fail++; $display("FAIL midwait_next ready=%b rsp_valid=%b exp 0001/0001", g, rvo); end
    endtask

    task automatic test_stray_dp_valid();
        @(negedge clk); bus.dp_valid = 1'b1; bus.dp_data_out = 8'hFF;
        @(negedge clk);
        #1;
        n_tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.rsp_data !== 8'h5A) begin
            n_fail++; $display("FAIL stray_idle rsp_valid=%b busy=%b rsp_data=%h exp 0000/0/5a", bus.rsp_valid, bus.busy, bus.rsp_data);
        end
        bus.dp_valid = 1'b0;
        @(negedge clk); bus.req_valid = 4'b1000; bus.req_data = 32'h66000000;
        @(negedge clk); bus.req_valid = '0; bus.dp_valid = 1'b1; bus.dp_data_out = 8'hFF;
        #1;
        n_tests++; if (bus.dp_start !== 1'b1 || bus.dp_data_in !== 8'h66) begin n_fail++; $display("FAIL stray_issue start=%b dp_in=%h exp 1/66", bus.dp_start, bus.dp_data_in); end
        @(negedge clk); bus.dp_valid = 1'b0;
        #1;
        n_tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL stray_wait1 rsp_valid=%b busy=%b exp 0000/1", bus.rsp_valid, bus.busy); end
        @(negedge clk); bus.dp_valid = 1'b1; bus.dp_data_out = 8'h33;
        #1;
        n_tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL stray_wait2 rsp_valid=%b busy=%b exp 0000/1", bus.rsp_valid, bus.busy); end
        @(negedge clk); bus.dp_valid = 1'b0;
        #1;
        n_tests++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 8'h33 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL stray_rsp valid=%b data=%h err=%b exp 1000/33/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.dp_valid    = 1'b0;
        bus.dp_data_out = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
`ifdef DP_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid_wait();
        test_stray_dp_valid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
